// File: rtl/tdc_channel.sv
// tdc_channel: single-hit carry-chain TDC with coarse counter, arm/hold FSM and valid/ready timestamp out.
// Latency: hit sampled at edge N is presented after edge N+2 (N+3 with TDC_POPCOUNT_EN).
// Backpressure: the timestamp is held while ts_ready is low; hits arriving meanwhile are counted in miss_count.
//
// Ports:
//   clock       system clock, also the STOP sample edge for the chain
//   reset       synchronous active-high reset
//   trigger     asynchronous hit (START), feeds carry-in of chain cell 0
//   arm         level; channel accepts hits while high
//   ts_valid    timestamp available (registered state decode, independent of ts_ready)
//   ts_ready    consumer accepts timestamp
//   ts_fine     fine interpolation code
//   ts_coarse   coarse counter value at the edge that sampled the hit
//   busy        high while a timestamp is presented or during dead time
//   miss_count  saturating count of hits lost while busy
//
// Build option: define TDC_POPCOUNT_EN for a bubble-tolerant popcount fine encoder
// (one extra pipeline clock on both fine and coarse paths).

module tdc_channel #(
  parameter int STAGES      = 64,
  parameter int FINE_W      = 7,
  parameter int COARSE_W    = 16,
  parameter int DEAD_CYCLES = 4,
  parameter int MISS_W      = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                trigger,
  input  logic                arm,
  output logic                ts_valid,
  input  logic                ts_ready,
  output logic [FINE_W-1:0]   ts_fine,
  output logic [COARSE_W-1:0] ts_coarse,
  output logic                busy,
  output logic [MISS_W-1:0]   miss_count
);

  localparam int DW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  // ---------------------------------------------------------------------------
  // Delay chain. Each SB_CARRY cell has I0=0, I1=1, so CO reduces to CI: every
  // tap is a copy of trigger, delayed in silicon by the cumulative carry delay.
  // ---------------------------------------------------------------------------
  logic [STAGES-1:0] chain;
  logic [STAGES-1:0] tap_in;

  always_comb begin
    logic ci;
    logic co;
    chain = '0;
    ci    = trigger;
    for (int i = 0; i < STAGES; i++) begin
      co       = (1'b0 & 1'b1) | (ci & (1'b0 | 1'b1));
      chain[i] = co;
      ci       = co;
    end
  end

  assign tap_in = chain;

  // Tap sample + metastability stage, coarse counter and its 2-deep alignment line.
  logic [STAGES-1:0]   tap_s1;
  logic [STAGES-1:0]   tap_s2;
  logic                tap0_prev;
  logic [COARSE_W-1:0] coarse_cnt;
  logic [COARSE_W-1:0] coarse_d1;
  logic [COARSE_W-1:0] coarse_d2;

  always_ff @(posedge clock) begin
    if (reset) begin
      tap_s1     <= '0;
      tap_s2     <= '0;
      tap0_prev  <= 1'b0;
      coarse_cnt <= '0;
      coarse_d1  <= '0;
      coarse_d2  <= '0;
    end else begin
      tap_s1     <= tap_in;
      tap_s2     <= tap_s1;
      tap0_prev  <= tap_s2[0];
      coarse_cnt <= coarse_cnt + COARSE_W'(1);
      // coarse_d1 holds the count that was current at the edge that loaded tap_s1
      coarse_d1  <= coarse_cnt;
      coarse_d2  <= coarse_d1;
    end
  end

  // Rising edge of the first tap marks a new hit.
  logic hit_raw;
  assign hit_raw = tap_s2[0] & ~tap0_prev;

  logic                hit;
  logic [FINE_W-1:0]   fine_code;
  logic [COARSE_W-1:0] coarse_code;

`ifdef TDC_POPCOUNT_EN
  // Popcount: per-byte partial sums registered, final sum combinational.
  localparam int GROUPS = (STAGES + 7) / 8;

  logic [GROUPS*8-1:0] tap_pad;
  logic [3:0]          psum   [GROUPS];
  logic [3:0]          psum_q [GROUPS];
  logic                hit_q;
  logic [COARSE_W-1:0] coarse_d3;

  always_comb begin
    tap_pad               = '0;
    tap_pad[STAGES-1:0]   = tap_s2;
    for (int g = 0; g < GROUPS; g++) begin
      psum[g] = '0;
      for (int b = 0; b < 8; b++) begin
        psum[g] = psum[g] + 4'(tap_pad[g*8+b]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int g = 0; g < GROUPS; g++) psum_q[g] <= '0;
      hit_q     <= 1'b0;
      coarse_d3 <= '0;
    end else begin
      for (int g = 0; g < GROUPS; g++) psum_q[g] <= psum[g];
      hit_q     <= hit_raw;
      coarse_d3 <= coarse_d2;
    end
  end

  always_comb begin
    fine_code = '0;
    for (int g = 0; g < GROUPS; g++) begin
      fine_code = fine_code + FINE_W'(psum_q[g]);
    end
  end

  assign hit         = hit_q;
  assign coarse_code = coarse_d3;
`else
  // Leading-ones: index of the lowest zero tap; all ones yields STAGES.
  always_comb begin
    fine_code = FINE_W'(STAGES);
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (!tap_s2[i]) fine_code = FINE_W'(i);
    end
  end

  assign hit         = hit_raw;
  assign coarse_code = coarse_d2;
`endif

  // ---------------------------------------------------------------------------
  // Arm / hold state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PRESENT = 2'd2,
    DEAD    = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          capture;
  logic          miss;
  logic [DW-1:0] dead_cnt;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    miss      = 1'b0;
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        // A hit beats a simultaneous arm drop.
        if (hit) begin
          capture   = 1'b1;
          state_nxt = PRESENT;
        end else if (!arm) begin
          state_nxt = IDLE;
        end
      end
      PRESENT: begin
        miss = hit;
        if (ts_ready) state_nxt = DEAD;
      end
      DEAD: begin
        miss = hit;
        if (dead_cnt == DW'(DEAD_CYCLES - 1)) state_nxt = arm ? ARMED : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      dead_cnt   <= '0;
      ts_fine    <= '0;
      ts_coarse  <= '0;
      miss_count <= '0;
    end else begin
      state <= state_nxt;
      if (state != DEAD) dead_cnt <= '0;
      else               dead_cnt <= dead_cnt + DW'(1);
      if (capture) begin
        ts_fine   <= fine_code;
        ts_coarse <= coarse_code;
      end
      if (miss && (miss_count != {MISS_W{1'b1}})) miss_count <= miss_count + MISS_W'(1);
    end
  end

  assign ts_valid = (state == PRESENT);
  assign busy     = (state == PRESENT) || (state == DEAD);

endmodule

// File: tb/tb_tdc_channel.sv
module tb_tdc_channel;

`ifdef TDC_POPCOUNT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int P = LAT - 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trig = 1'b0;
  logic        arm_i = 1'b0;
  logic        rdy = 1'b0;
  logic        valid;
  logic [6:0]  fine;
  logic [15:0] coarse;
  logic        busy;
  logic [7:0]  miss;

  logic        trig_w = 1'b0;
  logic        arm_w = 1'b0;
  logic        rdy_w = 1'b0;
  logic        valid_w;
  logic [3:0]  fine_w;
  logic [3:0]  coarse_w;
  logic        busy_w;
  logic [7:0]  miss_w;

  logic [63:0] taps_drv = '0;
  bit          use_trig = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tdc_channel dut (
    .clock(clk), .reset(rst), .trigger(trig), .arm(arm_i),
    .ts_valid(valid), .ts_ready(rdy), .ts_fine(fine), .ts_coarse(coarse),
    .busy(busy), .miss_count(miss)
  );

  tdc_channel #(.STAGES(8), .FINE_W(4), .COARSE_W(4), .DEAD_CYCLES(1), .MISS_W(8)) dut_w (
    .clock(clk), .reset(rst), .trigger(trig_w), .arm(arm_w),
    .ts_valid(valid_w), .ts_ready(rdy_w), .ts_fine(fine_w), .ts_coarse(coarse_w),
    .busy(busy_w), .miss_count(miss_w)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] pat_q[$];   // pat_q[t-1] = tap pattern sampled at edge t after reset
  int t;
  bit m_hold;
  int m_dead;
  bit m_armed;
  int m_miss;
  int m_fine;
  int m_coarse;

  function automatic int fine_of(input logic [63:0] p);
`ifdef TDC_POPCOUNT_EN
    return $countones(p);
`else
    int n = 0;
    while (n < 64 && p[n]) n++;
    return n;
`endif
  endfunction

  function automatic logic [63:0] therm(input int n);
    logic [63:0] one = 64'd1;
    if (n >= 64) return '1;
    return (one << n) - one;
  endfunction

  task automatic model_reset();
    pat_q.delete();
    t = 0; m_hold = 0; m_dead = 0; m_armed = 0; m_miss = 0; m_fine = 0; m_coarse = 0;
  endtask

  task automatic model_edge(input logic [63:0] p, input bit a, input bit r);
    bit hit = 0;
    int j = 0;
    pat_q.push_back(p);
    t++;
    if (t - LAT >= 1) begin
      j = t - LAT;
      hit = pat_q[j-1][0] && !((j >= 2) ? pat_q[j-2][0] : 1'b0);
    end
    if (m_hold) begin
      if (hit && m_miss < 255) m_miss++;
      if (r) begin m_hold = 0; m_dead = 4; end
    end else if (m_dead > 0) begin
      if (hit && m_miss < 255) m_miss++;
      m_dead--;
      if (m_dead == 0) m_armed = a;
    end else if (m_armed) begin
      if (hit) begin
        m_hold   = 1;
        m_fine   = fine_of(pat_q[j-1]);
        m_coarse = (j - 1) % 65536;
      end else if (!a) begin
        m_armed = 0;
      end
    end else begin
      m_armed = a;
    end
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input logic [63:0] pat, input bit a, input bit r, input bit rs);
    logic [63:0] eff;
    arm_i = a; rdy = r; rst = rs;
    if (use_trig) begin
      trig = pat[0];
      release dut.tap_in;
      eff = pat[0] ? '1 : '0;
    end else begin
      trig = 1'b0;
      taps_drv = pat;
      force dut.tap_in = taps_drv;
      eff = pat;
    end
    @(posedge clk);
    if (rs) model_reset();
    else    model_edge(eff, a, r);
    @(negedge clk);
    check("valid", 64'(valid), 64'(m_hold));
    check("busy", 64'(busy), 64'(m_hold || m_dead > 0));
    check("miss", 64'(miss), 64'(m_miss));
    if (m_hold) begin
      check("fine", 64'(fine), 64'(m_fine));
      check("coarse", 64'(coarse), 64'(m_coarse));
    end
  endtask

  task automatic idle(input int n, input bit a, input bit r);
    for (int i = 0; i < n; i++) step('0, a, r, 1'b0);
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Reset with trigger toggling through the real chain.
    use_trig = 1;
    step(64'd1, 1'b1, 1'b1, 1'b1);
    step(64'd0, 1'b1, 1'b1, 1'b1);
    step(64'd1, 1'b1, 1'b1, 1'b1);
    check("rst_valid", 64'(valid), 0);
    check("rst_fine", 64'(fine), 0);
    check("rst_coarse", 64'(coarse), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_miss", 64'(miss), 0);
    check("rst_valid_w", 64'(valid_w), 0);
    use_trig = 0;

    // Coarse wrap on the narrow instance, running alongside the main one.
    arm_w = 1; rdy_w = 1;
    for (int k = 1; k <= 100; k++) begin
      trig_w = (k == 16 || k == 17 || k == 19 || k == 20);
      step('0, 1'b1, 1'b0, 1'b0);
      if (k == 18 + P) begin
        check("wrap_valid1", 64'(valid_w), 1);
        check("wrap_coarse1", 64'(coarse_w), 15);
        check("wrap_fine1", 64'(fine_w), 8);
      end
      if (k == 19 + P) check("wrap_valid_drop", 64'(valid_w), 0);
      if (k == 21 + P) begin
        check("wrap_valid2", 64'(valid_w), 1);
        check("wrap_coarse2", 64'(coarse_w), 2);
      end
    end
    trig_w = 0;

    // Basic capture: 20 ones sampled when the counter reads 100.
    step(therm(20), 1'b1, 1'b0, 1'b0);
    step(therm(20), 1'b1, 1'b0, 1'b0);
    idle(LAT - 1, 1'b1, 1'b0);
    check("basic_valid", 64'(valid), 1);
    check("basic_fine", 64'(fine), 20);
    check("basic_coarse", 64'(coarse), 100);

    // Two more hits while presenting: timestamp untouched, two misses.
    step(therm(5), 1'b1, 1'b0, 1'b0);
    step(therm(5), 1'b1, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0);
    step(therm(9), 1'b1, 1'b0, 1'b0);
    step(therm(9), 1'b1, 1'b0, 1'b0);
    idle(LAT + 1, 1'b1, 1'b0);
    check("bp_miss", 64'(miss), 2);
    check("bp_fine", 64'(fine), 20);
    check("bp_coarse", 64'(coarse), 100);

    step('0, 1'b1, 1'b1, 1'b0);
    check("hs_valid", 64'(valid), 0);
    check("hs_busy", 64'(busy), 1);
    for (int d = 1; d <= 4; d++) begin
      step('0, 1'b1, 1'b0, 1'b0);
      check("dead_busy", 64'(busy), 64'(d < 4));
    end

    // Saturation of the miss counter.
    step(therm(30), 1'b1, 1'b0, 1'b0);
    step(therm(30), 1'b1, 1'b0, 1'b0);
    idle(LAT, 1'b1, 1'b0);
    for (int h = 0; h < 300; h++) begin
      step(therm(3), 1'b1, 1'b0, 1'b0);
      step(therm(3), 1'b1, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0, 1'b0);
    end
    idle(LAT, 1'b1, 1'b0);
    check("sat_miss", 64'(miss), 255);
    check("sat_fine", 64'(fine), 30);
    idle(1, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b0);

    // Bubble inside the thermometer: 1110111000...
    step(64'h77, 1'b1, 1'b0, 1'b0);
    step(64'h77, 1'b1, 1'b0, 1'b0);
    idle(LAT, 1'b1, 1'b0);
`ifdef TDC_POPCOUNT_EN
    check("bubble_fine", 64'(fine), 6);
`else
    check("bubble_fine", 64'(fine), 3);
`endif
    idle(1, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b0);

    // Hit while disarmed is ignored entirely.
    idle(2, 1'b0, 1'b0);
    step(therm(12), 1'b0, 1'b0, 1'b0);
    step(therm(12), 1'b0, 1'b0, 1'b0);
    idle(LAT + 2, 1'b0, 1'b0);
    check("noarm_valid", 64'(valid), 0);
    check("noarm_miss", 64'(miss), 255);

    // arm falls on the very cycle the hit is evaluated: hit wins.
    idle(2, 1'b1, 1'b0);
    step(therm(7), 1'b1, 1'b0, 1'b0);
    step(therm(7), 1'b1, 1'b0, 1'b0);
    idle(LAT - 2, 1'b1, 1'b0);
    step('0, 1'b0, 1'b0, 1'b0);
    check("armfall_valid", 64'(valid), 1);
    check("armfall_fine", 64'(fine), 7);
    idle(1, 1'b0, 1'b1);
    idle(5, 1'b0, 1'b0);
    step(therm(4), 1'b0, 1'b0, 1'b0);
    step(therm(4), 1'b0, 1'b0, 1'b0);
    idle(LAT + 1, 1'b0, 1'b0);
    check("armfall_idle", 64'(valid), 0);

    // Real trigger through the chain: all taps high.
    use_trig = 1;
    idle(2, 1'b1, 1'b0);
    step(64'd1, 1'b1, 1'b0, 1'b0);
    step(64'd1, 1'b1, 1'b0, 1'b0);
    step(64'd1, 1'b1, 1'b0, 1'b0);
    idle(LAT - 1, 1'b1, 1'b0);
    check("trig_valid", 64'(valid), 1);
    check("trig_fine", 64'(fine), 64);
    idle(1, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b0);
    use_trig = 0;

    // Reset in the middle of a held timestamp.
    step(therm(10), 1'b1, 1'b0, 1'b0);
    step(therm(10), 1'b1, 1'b0, 1'b0);
    idle(LAT, 1'b1, 1'b0);
    check("mid_pre_valid", 64'(valid), 1);
    step('0, 1'b1, 1'b0, 1'b1);
    check("mid_valid", 64'(valid), 0);
    check("mid_fine", 64'(fine), 0);
    check("mid_coarse", 64'(coarse), 0);
    check("mid_miss", 64'(miss), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [63:0] p;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) p = '0;
      else begin
        p = therm(int'($urandom_range(1, 64)));
        if (r == 9) p[$urandom_range(1, 63)] = 1'b0;
      end
      step(p, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
